// File: rtl/cc_noise_encoder.sv
// cc_noise_encoder
//   Parametrised rate-1/2 convolutional encoder with a rate-limited
//   channel-noise injector. Each valid input bit produces one registered
//   symbol (out1, out2). On request, one of the two coded bits is inverted,
//   and at most one error is injected per MIN_GAP+1 valid symbols.
//
// Configuration macro: CC_NOISE_INJECT_EN
//   defined   -> noise injector, guard counter and error counter are built
//   undefined -> pure encoder; noise0/noise1 ignored, noise_ready = 0,
//                noise_cnt = 0
//
// Parameters
//   K        constraint length, 2..16
//   G0, G1   generators for out1 / out2; bit 0 taps the current input,
//            bit K-1 taps the oldest retained bit
//   MIN_GAP  valid symbols that must separate two injected errors, 1..255
//   CNT_W    width of the saturating injected-error counter
//
// Ports
//   clock        sole clock, all state updates on posedge
//   reset        synchronous, active-high
//   in           data bit, qualified by in_valid
//   in_valid     qualifies in, noise0 and noise1
//   noise0       request to flip out1 of this symbol (has priority)
//   noise1       request to flip out2 of this symbol
//   out1, out2   registered coded bits (G0 / G1 parity)
//   out_valid    out1/out2 hold a new symbol this cycle
//   noise_ready  an injection would be accepted this cycle
//   noise_cnt    number of injected errors, saturating at all-ones
module cc_noise_encoder #(
  parameter int           K       = 3,
  parameter logic [K-1:0] G0      = 3'b101,
  parameter logic [K-1:0] G1      = 3'b111,
  parameter int           MIN_GAP = 3,
  parameter int           CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  input  logic             noise0,
  input  logic             noise1,
  output logic             out1,
  output logic             out2,
  output logic             out_valid,
  output logic             noise_ready,
  output logic [CNT_W-1:0] noise_cnt
);

  // Elaboration-time parameter checks.
  if (K < 2 || K > 16) begin : g_bad_k
    $error("cc_noise_encoder: K must be in 2..16");
  end
  if (G0[0] == 1'b0 || G0[K-1] == 1'b0 || G1[0] == 1'b0 || G1[K-1] == 1'b0) begin : g_bad_g
    $error("cc_noise_encoder: generators must tap both the current and the oldest bit");
  end
  if (MIN_GAP < 1 || MIN_GAP > 255) begin : g_bad_gap
    $error("cc_noise_encoder: MIN_GAP must be in 1..255");
  end

  // Encoder state: sr[0] is the newest retained bit, sr[K-2] the oldest.
  logic [K-2:0] sr_q, sr_d, sr_next;
  logic         out1_q, out1_d;
  logic         out2_q, out2_d;
  logic         out_valid_q, out_valid_d;

  logic [K-1:0] w;
  logic         f0, f1;

  assign w = {sr_q, in};

  // A two-bit window keeps a single history bit, so there is nothing to shift.
  if (K == 2) begin : g_sr_k2
    assign sr_next = in;
  end else begin : g_sr_kn
    assign sr_next = {sr_q[K-3:0], in};
  end

`ifdef CC_NOISE_INJECT_EN
  localparam int GAP_W = $clog2(MIN_GAP + 1);

  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] noise_cnt_q, noise_cnt_d;
  logic             ready;
  logic             inj;

  assign ready = (gap_q == '0);
  assign inj   = in_valid & ready & (noise0 | noise1);
  // noise0 wins when both are requested, so at most one bit flips per symbol.
  assign f0    = inj & noise0;
  assign f1    = inj & noise1 & ~noise0;

  // The guard counts valid symbols, not cycles; idle cycles freeze it.
  always_comb begin
    gap_d       = gap_q;
    noise_cnt_d = noise_cnt_q;
    if (in_valid) begin
      if (inj) begin
        gap_d = GAP_W'(MIN_GAP);
        if (noise_cnt_q != '1) begin
          noise_cnt_d = noise_cnt_q + 1'b1;
        end
      end else if (gap_q != '0) begin
        gap_d = gap_q - 1'b1;
      end
    end
  end

  // Starting the guard at MIN_GAP keeps the channel clean for the first
  // MIN_GAP symbols after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      gap_q       <= GAP_W'(MIN_GAP);
      noise_cnt_q <= '0;
    end else begin
      gap_q       <= gap_d;
      noise_cnt_q <= noise_cnt_d;
    end
  end

  assign noise_ready = ready;
  assign noise_cnt   = noise_cnt_q;
`else
  logic unused_noise;
  assign unused_noise = noise0 ^ noise1;

  assign f0          = 1'b0;
  assign f1          = 1'b0;
  assign noise_ready = 1'b0;
  assign noise_cnt   = '0;
`endif

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch instead of plain combinational logic.
  always_comb begin
    sr_d        = sr_q;
    out1_d      = out1_q;
    out2_d      = out2_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      sr_d        = sr_next;
      out1_d      = (^(G0 & w)) ^ f0;
      out2_d      = (^(G1 & w)) ^ f1;
      out_valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // Reset has priority, so a symbol presented during reset is discarded.
  always_ff @(posedge clock) begin
    if (reset) begin
      sr_q        <= '0;
      out1_q      <= 1'b0;
      out2_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      out1_q      <= out1_d;
      out2_q      <= out2_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out1      = out1_q;
  assign out2      = out2_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cc_noise_encoder.sv
// Directed bench for cc_noise_encoder. Expected symbols are hand-computed
// for K=3, G0=101, G1=111; the injector-dependent expectations follow the
// CC_NOISE_INJECT_EN macro so the bench fits either build.
module tb_cc_noise_encoder;

`ifdef CC_NOISE_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       in;
  logic       in_valid;
  logic       noise0;
  logic       noise1;

  logic       a_out1, a_out2, a_out_valid, a_noise_ready;
  logic [7:0] a_noise_cnt;
  logic       b_out1, b_out2, b_out_valid, b_noise_ready;
  logic [1:0] b_noise_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cc_noise_encoder dut_a (
    .clock       (clock),
    .reset       (reset),
    .in          (in),
    .in_valid    (in_valid),
    .noise0      (noise0),
    .noise1      (noise1),
    .out1        (a_out1),
    .out2        (a_out2),
    .out_valid   (a_out_valid),
    .noise_ready (a_noise_ready),
    .noise_cnt   (a_noise_cnt)
  );

  cc_noise_encoder #(.MIN_GAP(1), .CNT_W(2)) dut_b (
    .clock       (clock),
    .reset       (reset),
    .in          (in),
    .in_valid    (in_valid),
    .noise0      (noise0),
    .noise1      (noise1),
    .out1        (b_out1),
    .out2        (b_out2),
    .out_valid   (b_out_valid),
    .noise_ready (b_noise_ready),
    .noise_cnt   (b_noise_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic step(input logic i, input logic v, input logic n0, input logic n1);
    in       = i;
    in_valid = v;
    noise0   = n0;
    noise1   = n1;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  // {out_valid, out1, out2} of dut_a
  function automatic logic [2:0] sym_a();
    return {a_out_valid, a_out1, a_out2};
  endfunction

  // Clean stream 1,0,1,1 from zero history -> 11, 01, 00, 10
  logic [3:0] s1_in  = 4'b1101;       // bit i = symbol i
  logic [1:0] s1_exp [4] = '{2'b11, 2'b01, 2'b00, 2'b10};

  // Stream 1,0,1,1,0,0,1,0 with noise0 held: clean parity, then flips on 4th/8th
  logic [7:0] s2_in  = 8'b0100_1101;
  logic [1:0] s2_exp [8] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b01};
  logic [7:0] s2_flip = 8'b1000_1000;
  logic [7:0] s2_rdy  = 8'b0100_0100;
  int         s2_cnt [8] = '{0, 0, 0, 1, 1, 1, 1, 2};

  initial begin
    reset = 1'b1; in = 1'b0; in_valid = 1'b0; noise0 = 1'b0; noise1 = 1'b0;
    do_reset();

    // Reset state
    check("rst_sym",   {29'd0, sym_a()}, 32'd0);
    check("rst_cnt",   {24'd0, a_noise_cnt}, 32'd0);
    check("rst_ready", {31'd0, a_noise_ready}, 32'd0);

    // Clean stream; guard reaches zero after the 3rd symbol
    for (int i = 0; i < 4; i++) begin
      step(s1_in[i], 1'b1, 1'b0, 1'b0);
      check($sformatf("s1_sym%0d", i), {29'd0, sym_a()}, {29'd0, 1'b1, s1_exp[i]});
      check($sformatf("s1_rdy%0d", i), {31'd0, a_noise_ready}, {31'd0, INJ && i >= 2});
    end

    // Idle gap: outputs hold, out_valid low, guard frozen (sr = 11 retained)
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1);
      check($sformatf("idle_sym%0d", i), {29'd0, sym_a()}, {29'd0, 3'b010});
      check($sformatf("idle_rdy%0d", i), {31'd0, a_noise_ready}, {31'd0, INJ});
    end
    check("idle_cnt", {24'd0, a_noise_cnt}, 32'd0);

    // Resume: in=0 with sr=11 -> 10; in=1 with sr=10 -> 00
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("resume0", {29'd0, sym_a()}, {29'd0, 3'b110});
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("resume1", {29'd0, sym_a()}, {29'd0, 3'b100});

    // Both noise requests on a ready symbol: in=0, sr=01 -> clean 01, out1 flips
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("both_sym",   {29'd0, sym_a()}, {29'd0, 1'b1, INJ, 1'b1});
    check("both_cnt",   {24'd0, a_noise_cnt}, {31'd0, INJ});
    check("both_ready", {31'd0, a_noise_ready}, 32'd0);

    // noise1 requests while guarded are dropped: in=0 -> 11, 00, 00
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("drop_sym0", {29'd0, sym_a()}, {29'd0, 3'b111});
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("drop_sym1", {29'd0, sym_a()}, {29'd0, 3'b100});
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("drop_sym2", {29'd0, sym_a()}, {29'd0, 3'b100});
    check("drop_cnt",  {24'd0, a_noise_cnt}, {31'd0, INJ});
    check("drop_rdy",  {31'd0, a_noise_ready}, {31'd0, INJ});

    // noise1 alone on a ready symbol flips out2
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("n1_sym", {29'd0, sym_a()}, {29'd0, 1'b1, 1'b0, INJ});
    check("n1_cnt", {24'd0, a_noise_cnt}, INJ ? 32'd2 : 32'd0);

    // Reset alongside a valid symbol: symbol discarded, state cleared
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    check("mrst_sym",   {29'd0, sym_a()}, 32'd0);
    check("mrst_cnt",   {24'd0, a_noise_cnt}, 32'd0);
    check("mrst_ready", {31'd0, a_noise_ready}, 32'd0);

    // Re-run of the clean stream reproduces the same symbols
    for (int i = 0; i < 4; i++) begin
      step(s1_in[i], 1'b1, 1'b0, 1'b0);
      check($sformatf("rerun_sym%0d", i), {29'd0, sym_a()}, {29'd0, 1'b1, s1_exp[i]});
    end

    // noise0 held from reset: out1 inverted on symbols 4 and 8
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(s2_in[i], 1'b1, 1'b1, 1'b0);
      check($sformatf("hold_sym%0d", i), {29'd0, sym_a()},
            {29'd0, 1'b1, s2_exp[i][1] ^ (INJ & s2_flip[i]), s2_exp[i][0]});
      check($sformatf("hold_cnt%0d", i), {24'd0, a_noise_cnt}, INJ ? s2_cnt[i] : 0);
      check($sformatf("hold_rdy%0d", i), {31'd0, a_noise_ready}, {31'd0, INJ & s2_rdy[i]});
    end

    // MIN_GAP=1, CNT_W=2: injection every other symbol, counter saturates at 3
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check($sformatf("sat_out%0d", k), {29'd0, b_out_valid, b_out1, b_out2},
            {29'd0, 1'b1, INJ && (k % 2 == 0), 1'b0});
      check($sformatf("sat_cnt%0d", k), {30'd0, b_noise_cnt},
            INJ ? ((k / 2 > 3) ? 3 : k / 2) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
